// File: rtl/mem_stage_pkg.sv
// ----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory-access pipeline stage: ALU op encodings
// (load/store subset plus a couple of non-memory ops), widths, FSM states and
// small decode helpers used by mem_stage and mem_align.
// The backtick macros mirror the localparams for code that prefers the
// classic config-header spelling.
// ----------------------------------------------------------------------------

`ifndef MEM_STAGE_DEFINES
`define MEM_STAGE_DEFINES
`define ALU_OP_WIDTH 8
`define REG_WIDTH    5
`define ZeroWord     32'h0000_0000
`define ALU_LB       8'h10
`define ALU_LH       8'h11
`define ALU_LW       8'h12
`define ALU_LBU      8'h13
`define ALU_LHU      8'h14
`define ALU_SB       8'h18
`define ALU_SH       8'h19
`define ALU_SW       8'h1A
`endif

package mem_stage_pkg;

   localparam int ALU_OP_W = 8;
   localparam int REG_W    = 5;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   localparam logic [ALU_OP_W-1:0] ALU_NOP = 8'h00;
   localparam logic [ALU_OP_W-1:0] ALU_ADD = 8'h01;
   localparam logic [ALU_OP_W-1:0] ALU_LB  = 8'h10;
   localparam logic [ALU_OP_W-1:0] ALU_LH  = 8'h11;
   localparam logic [ALU_OP_W-1:0] ALU_LW  = 8'h12;
   localparam logic [ALU_OP_W-1:0] ALU_LBU = 8'h13;
   localparam logic [ALU_OP_W-1:0] ALU_LHU = 8'h14;
   localparam logic [ALU_OP_W-1:0] ALU_SB  = 8'h18;
   localparam logic [ALU_OP_W-1:0] ALU_SH  = 8'h19;
   localparam logic [ALU_OP_W-1:0] ALU_SW  = 8'h1A;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   function automatic logic is_load(input logic [ALU_OP_W-1:0] op);
      return (op == ALU_LB) || (op == ALU_LH) || (op == ALU_LW) ||
             (op == ALU_LBU) || (op == ALU_LHU);
   endfunction

   function automatic logic is_store(input logic [ALU_OP_W-1:0] op);
      return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
   endfunction

   function automatic logic is_mem_op(input logic [ALU_OP_W-1:0] op);
      return is_load(op) || is_store(op);
   endfunction

   function automatic size_e op_size(input logic [ALU_OP_W-1:0] op);
      size_e sz;
      case (op)
         ALU_LB, ALU_LBU, ALU_SB: sz = SZ_BYTE;
         ALU_LH, ALU_LHU, ALU_SH: sz = SZ_HALF;
         default:                 sz = SZ_WORD;
      endcase
      return sz;
   endfunction

   function automatic logic is_unsigned_load(input logic [ALU_OP_W-1:0] op);
      return (op == ALU_LBU) || (op == ALU_LHU);
   endfunction

   // Halfwords must sit on an even address, words on a multiple of four.
   function automatic logic is_misaligned(input logic [ALU_OP_W-1:0] op,
                                          input logic [1:0]          lo);
      size_e sz;
      sz = op_size(op);
      return is_mem_op(op) &&
             (((sz == SZ_HALF) && lo[0]) || ((sz == SZ_WORD) && (lo != 2'b00)));
   endfunction

endpackage

// File: rtl/mem_align.sv
// ----------------------------------------------------------------------------
// mem_align
// Purely combinational byte-lane steering for the memory stage.
//   op_i          : ALU op (selects access size / signedness)
//   addr_lo_i     : low two address bits (lane selector, little-endian)
//   store_data_i  : rs2 value for stores
//   rdata_i       : raw word returned by the data bus
//   be_o          : byte enables for the bus
//   wdata_o       : store data replicated across all lanes
//   load_data_o   : lane-shifted and sign/zero-extended load result
// Offending low bits are dropped (halfword ignores bit 0, word ignores both),
// which gives forced alignment when misaligned trapping is not built in.
// ----------------------------------------------------------------------------
module mem_align
   import mem_stage_pkg::*;
(
   input  logic [ALU_OP_W-1:0] op_i,
   input  logic [1:0]          addr_lo_i,
   input  logic [31:0]         store_data_i,
   input  logic [31:0]         rdata_i,
   output logic [3:0]          be_o,
   output logic [31:0]         wdata_o,
   output logic [31:0]         load_data_o
);

   size_e       size;
   logic [1:0]  lane;
   logic [31:0] shifted;

   // Lane selection, enables and replicated store data.
   always_comb begin
      size    = op_size(op_i);
      lane    = addr_lo_i;
      be_o    = 4'hF;
      wdata_o = store_data_i;
      case (size)
         SZ_BYTE: begin
            be_o    = 4'b0001 << lane;
            wdata_o = {4{store_data_i[7:0]}};
         end
         SZ_HALF: begin
            lane[0] = 1'b0;
            be_o    = 4'b0011 << lane;
            wdata_o = {2{store_data_i[15:0]}};
         end
         default: begin
            lane = 2'b00;
         end
      endcase
   end

   // Bring the addressed lane down to bit 0, then extend to a full word.
   always_comb begin
      shifted     = rdata_i >> {lane, 3'b000};
      load_data_o = shifted;
      case (size)
         SZ_BYTE: load_data_o = is_unsigned_load(op_i) ?
                                {24'h0, shifted[7:0]} :
                                {{24{shifted[7]}}, shifted[7:0]};
         SZ_HALF: load_data_o = is_unsigned_load(op_i) ?
                                {16'h0, shifted[15:0]} :
                                {{16{shifted[15]}}, shifted[15:0]};
         default: load_data_o = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
// Memory-access pipeline stage. Non-memory results pass straight to the
// registered write-back bundle. Loads/stores are latched and driven onto a
// req/gnt/rvalid data bus while stallreq holds the upstream pipeline.
// Ports:
//   CLK, RST                 : clock, synchronous active-low reset
//   AluOP_i .. rd_data_i     : EX-stage result bundle
//   mem_req/we/addr/be/wdata : bus request side (held stable until mem_gnt)
//   mem_gnt/rvalid/rdata     : bus response side
//   rd_o/rd_op_o/rd_data_o   : registered write-back bundle
//   stallreq                 : hold upstream while an access is outstanding
// Optional build macro MISALIGN_TRAP_EN adds misalign_o / badaddr_o and
// suppresses bus requests for misaligned halfword/word accesses.
// ----------------------------------------------------------------------------
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [ALU_OP_W-1:0] AluOP_i,
   input  logic [31:0]         mem_addr_i,
   input  logic [DATA_W-1:0]   store_data_i,
   input  logic [REG_W-1:0]    rd_i,
   input  logic                rd_op_i,
   input  logic [DATA_W-1:0]   rd_data_i,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [3:0]          mem_be,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic [REG_W-1:0]    rd_o,
   output logic                rd_op_o,
   output logic [DATA_W-1:0]   rd_data_o,
`ifdef MISALIGN_TRAP_EN
   output logic                misalign_o,
   output logic [31:0]         badaddr_o,
`endif
   output logic                stallreq
);

   state_e              state_q, state_d;
   logic [ALU_OP_W-1:0] op_q, op_d;
   logic [31:0]         addr_q, addr_d;
   logic [DATA_W-1:0]   sdata_q, sdata_d;
   logic [REG_W-1:0]    rd_q, rd_d;
   logic                rdop_q, rdop_d;
   logic [REG_W-1:0]    wbRd_q, wbRd_d;
   logic                wbRdOp_q, wbRdOp_d;
   logic [DATA_W-1:0]   wbData_q, wbData_d;
   logic                stall;
   logic                trap;
   logic [DATA_W-1:0]   loadData;
`ifdef MISALIGN_TRAP_EN
   logic                misalign_q, misalign_d;
   logic [31:0]         badaddr_q, badaddr_d;
`endif

   mem_align u_align (
      .op_i         (op_q),
      .addr_lo_i    (addr_q[1:0]),
      .store_data_i (sdata_q),
      .rdata_i      (mem_rdata),
      .be_o         (mem_be),
      .wdata_o      (mem_wdata),
      .load_data_o  (loadData)
   );

`ifdef MISALIGN_TRAP_EN
   assign trap = is_misaligned(AluOP_i, mem_addr_i[1:0]);
`else
   assign trap = 1'b0;
`endif

   // State register plus latched request fields and write-back bundle.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q    <= ST_IDLE;
         op_q       <= '0;
         addr_q     <= '0;
         sdata_q    <= '0;
         rd_q       <= '0;
         rdop_q     <= 1'b0;
         wbRd_q     <= '0;
         wbRdOp_q   <= 1'b0;
         wbData_q   <= '0;
`ifdef MISALIGN_TRAP_EN
         misalign_q <= 1'b0;
         badaddr_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         sdata_q    <= sdata_d;
         rd_q       <= rd_d;
         rdop_q     <= rdop_d;
         wbRd_q     <= wbRd_d;
         wbRdOp_q   <= wbRdOp_d;
         wbData_q   <= wbData_d;
`ifdef MISALIGN_TRAP_EN
         misalign_q <= misalign_d;
         badaddr_q  <= badaddr_d;
`endif
      end
   end

   // Next-state and write-back selection. Any cycle that is not a retiring
   // ALU op or a completing load writes a bubble (rd_op_o = 0).
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      addr_d   = addr_q;
      sdata_d  = sdata_q;
      rd_d     = rd_q;
      rdop_d   = rdop_q;
      wbRd_d   = wbRd_q;
      wbRdOp_d = 1'b0;
      wbData_d = wbData_q;
      stall    = 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_d = 1'b0;
      badaddr_d  = badaddr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (is_mem_op(AluOP_i) && trap) begin
`ifdef MISALIGN_TRAP_EN
               misalign_d = 1'b1;
               badaddr_d  = mem_addr_i;
`endif
            end else if (is_mem_op(AluOP_i)) begin
               op_d    = AluOP_i;
               addr_d  = mem_addr_i;
               sdata_d = store_data_i;
               rd_d    = rd_i;
               rdop_d  = rd_op_i;
               stall   = 1'b1;
               state_d = ST_REQ;
            end else begin
               wbRd_d   = rd_i;
               wbRdOp_d = rd_op_i;
               wbData_d = rd_data_i;
            end
         end
         ST_REQ: begin
            stall = 1'b1;
            if (mem_gnt) begin
               if (!is_load(op_q)) begin
                  stall   = 1'b0;
                  state_d = ST_IDLE;
               end else if (mem_rvalid) begin
                  stall    = 1'b0;
                  wbRd_d   = rd_q;
                  wbRdOp_d = rdop_q;
                  wbData_d = loadData;
                  state_d  = ST_IDLE;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            stall = 1'b1;
            if (mem_rvalid) begin
               stall    = 1'b0;
               wbRd_d   = rd_q;
               wbRdOp_d = rdop_q;
               wbData_d = loadData;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Reset gates the request and stall immediately rather than a cycle later.
   assign mem_req   = RST && (state_q == ST_REQ);
   assign stallreq  = RST && stall;
   assign mem_we    = is_store(op_q);
   assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign rd_o      = wbRd_q;
   assign rd_op_o   = wbRdOp_q;
   assign rd_data_o = wbData_q;
`ifdef MISALIGN_TRAP_EN
   assign misalign_o = misalign_q;
   assign badaddr_o  = badaddr_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_stage
// Directed self-checking bench for mem_stage. Inputs change 1ns after each
// rising edge; registered outputs are checked then, combinational outputs
// another 1ns later once the new inputs have settled.
// ----------------------------------------------------------------------------
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic                CLK = 1'b0;
   logic                RST;
   logic [ALU_OP_W-1:0] AluOP_i;
   logic [31:0]         mem_addr_i;
   logic [31:0]         store_data_i;
   logic [REG_W-1:0]    rd_i;
   logic                rd_op_i;
   logic [31:0]         rd_data_i;
   logic                mem_req;
   logic                mem_we;
   logic [31:0]         mem_addr;
   logic [3:0]          mem_be;
   logic [31:0]         mem_wdata;
   logic                mem_gnt;
   logic                mem_rvalid;
   logic [31:0]         mem_rdata;
   logic [REG_W-1:0]    rd_o;
   logic                rd_op_o;
   logic [31:0]         rd_data_o;
   logic                stallreq;
`ifdef MISALIGN_TRAP_EN
   logic                misalign_o;
   logic [31:0]         badaddr_o;
`endif

   int testCount = 0;
   int failCount = 0;

   mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .AluOP_i      (AluOP_i),
      .mem_addr_i   (mem_addr_i),
      .store_data_i (store_data_i),
      .rd_i         (rd_i),
      .rd_op_i      (rd_op_i),
      .rd_data_i    (rd_data_i),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_be       (mem_be),
      .mem_wdata    (mem_wdata),
      .mem_gnt      (mem_gnt),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .rd_o         (rd_o),
      .rd_op_o      (rd_op_o),
      .rd_data_o    (rd_data_o),
`ifdef MISALIGN_TRAP_EN
      .misalign_o   (misalign_o),
      .badaddr_o    (badaddr_o),
`endif
      .stallreq     (stallreq)
   );

   always #5 CLK = ~CLK;

   // Advance to 1ns after the next rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic applyStimulus(input logic [ALU_OP_W-1:0] op,
                                input logic [31:0]         addr,
                                input logic [31:0]         sdata,
                                input logic [REG_W-1:0]    rd,
                                input logic                rdop,
                                input logic [31:0]         rdata);
      AluOP_i      = op;
      mem_addr_i   = addr;
      store_data_i = sdata;
      rd_i         = rd;
      rd_op_i      = rdop;
      rd_data_i    = rdata;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   initial begin
      RST        = 1'b0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      applyStimulus(ALU_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
      tick();
      tick();
      checkOutput("reset rd_o", 32'(rd_o), 32'd0);
      checkOutput("reset rd_op_o", 32'(rd_op_o), 32'd0);
      checkOutput("reset rd_data_o", rd_data_o, 32'd0);
      checkOutput("reset mem_req", 32'(mem_req), 32'd0);
      checkOutput("reset stallreq", 32'(stallreq), 32'd0);
      RST = 1'b1;

      // Plain ALU op passes through with one cycle of latency.
      applyStimulus(ALU_ADD, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234);
      #1;
      checkOutput("add stallreq", 32'(stallreq), 32'd0);
      tick();
      checkOutput("add rd_o", 32'(rd_o), 32'd5);
      checkOutput("add rd_op_o", 32'(rd_op_o), 32'd1);
      checkOutput("add rd_data_o", rd_data_o, 32'h1234);
      checkOutput("add stallreq2", 32'(stallreq), 32'd0);

      // SW with grant on the third request cycle.
      applyStimulus(ALU_SW, 32'h100, 32'hDEADBEEF, 5'd0, 1'b0, 32'h0);
      #1;
      checkOutput("sw stall idle", 32'(stallreq), 32'd1);
      checkOutput("sw req idle", 32'(mem_req), 32'd0);
      tick();
      checkOutput("sw req c1", 32'(mem_req), 32'd1);
      checkOutput("sw we c1", 32'(mem_we), 32'd1);
      checkOutput("sw addr c1", mem_addr, 32'h100);
      checkOutput("sw be c1", 32'(mem_be), 32'hF);
      checkOutput("sw wdata c1", mem_wdata, 32'hDEADBEEF);
      checkOutput("sw stall c1", 32'(stallreq), 32'd1);
      checkOutput("sw bubble", 32'(rd_op_o), 32'd0);
      tick();
      checkOutput("sw req c2", 32'(mem_req), 32'd1);
      checkOutput("sw addr c2", mem_addr, 32'h100);
      checkOutput("sw wdata c2", mem_wdata, 32'hDEADBEEF);
      checkOutput("sw stall c2", 32'(stallreq), 32'd1);
      tick();
      mem_gnt = 1'b1;
      #1;
      checkOutput("sw req c3", 32'(mem_req), 32'd1);
      checkOutput("sw addr c3", mem_addr, 32'h100);
      checkOutput("sw be c3", 32'(mem_be), 32'hF);
      checkOutput("sw stall gnt", 32'(stallreq), 32'd0);
      applyStimulus(ALU_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
      tick();
      mem_gnt = 1'b0;
      checkOutput("sw req done", 32'(mem_req), 32'd0);
      checkOutput("sw rd_op_o", 32'(rd_op_o), 32'd0);

      // LB at lane 3, grant then rvalid a cycle later.
      applyStimulus(ALU_LB, 32'h103, 32'h0, 5'd7, 1'b1, 32'h0);
      tick();
      checkOutput("lb be", 32'(mem_be), 32'h8);
      checkOutput("lb we", 32'(mem_we), 32'd0);
      checkOutput("lb addr", mem_addr, 32'h100);
      mem_gnt = 1'b1;
      #1;
      checkOutput("lb stall gnt", 32'(stallreq), 32'd1);
      tick();
      mem_gnt = 1'b0;
      checkOutput("lb req wait", 32'(mem_req), 32'd0);
      checkOutput("lb stall wait", 32'(stallreq), 32'd1);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h80FF0000;
      #1;
      checkOutput("lb stall rvalid", 32'(stallreq), 32'd0);
      applyStimulus(ALU_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
      tick();
      mem_rvalid = 1'b0;
      checkOutput("lb rd_o", 32'(rd_o), 32'd7);
      checkOutput("lb rd_op_o", 32'(rd_op_o), 32'd1);
      checkOutput("lb rd_data_o", rd_data_o, 32'hFFFFFF80);

      // LBU, same address and data.
      applyStimulus(ALU_LBU, 32'h103, 32'h0, 5'd8, 1'b1, 32'h0);
      tick();
      mem_gnt = 1'b1;
      #1;
      tick();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h80FF0000;
      #1;
      applyStimulus(ALU_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
      tick();
      mem_rvalid = 1'b0;
      checkOutput("lbu rd_o", 32'(rd_o), 32'd8);
      checkOutput("lbu rd_data_o", rd_data_o, 32'h00000080);

      // LH at 0x102 with grant and rvalid together.
      applyStimulus(ALU_LH, 32'h102, 32'h0, 5'd9, 1'b1, 32'h0);
      #1;
      checkOutput("lh stall idle", 32'(stallreq), 32'd1);
      tick();
      checkOutput("lh be", 32'(mem_be), 32'hC);
      checkOutput("lh stall req", 32'(stallreq), 32'd1);
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h80011234;
      #1;
      checkOutput("lh stall gnt", 32'(stallreq), 32'd0);
      applyStimulus(ALU_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
      tick();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      checkOutput("lh rd_o", 32'(rd_o), 32'd9);
      checkOutput("lh rd_op_o", 32'(rd_op_o), 32'd1);
      checkOutput("lh rd_data_o", rd_data_o, 32'hFFFF8001);
      checkOutput("lh req after", 32'(mem_req), 32'd0);

      // LHU low half, zero-extended.
      applyStimulus(ALU_LHU, 32'h200, 32'h0, 5'd10, 1'b1, 32'h0);
      tick();
      checkOutput("lhu be", 32'(mem_be), 32'h3);
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h12348765;
      #1;
      applyStimulus(ALU_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
      tick();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      checkOutput("lhu rd_data_o", rd_data_o, 32'h00008765);

      // SB lane replication.
      applyStimulus(ALU_SB, 32'h101, 32'h000000A5, 5'd0, 1'b0, 32'h0);
      tick();
      checkOutput("sb be", 32'(mem_be), 32'h2);
      checkOutput("sb wdata", mem_wdata, 32'hA5A5A5A5);
      checkOutput("sb we", 32'(mem_we), 32'd1);
      mem_gnt = 1'b1;
      #1;
      applyStimulus(ALU_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
      tick();
      mem_gnt = 1'b0;

      // SH lane replication.
      applyStimulus(ALU_SH, 32'h102, 32'h1234BEEF, 5'd0, 1'b0, 32'h0);
      tick();
      checkOutput("sh be", 32'(mem_be), 32'hC);
      checkOutput("sh wdata", mem_wdata, 32'hBEEFBEEF);
      mem_gnt = 1'b1;
      #1;
      applyStimulus(ALU_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
      tick();
      mem_gnt = 1'b0;
      checkOutput("sh req done", 32'(mem_req), 32'd0);

      // Load to x0 still accesses the bus and keeps rd_op as supplied.
      applyStimulus(ALU_LW, 32'h104, 32'h0, 5'd0, 1'b1, 32'h0);
      tick();
      checkOutput("lw x0 req", 32'(mem_req), 32'd1);
      checkOutput("lw x0 addr", mem_addr, 32'h104);
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFEF00D;
      #1;
      applyStimulus(ALU_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
      tick();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      checkOutput("lw x0 rd_o", 32'(rd_o), 32'd0);
      checkOutput("lw x0 rd_op_o", 32'(rd_op_o), 32'd1);
      checkOutput("lw x0 rd_data_o", rd_data_o, 32'hCAFEF00D);

      // gnt/rvalid in IDLE are ignored.
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h55555555;
      tick();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      checkOutput("idle gnt req", 32'(mem_req), 32'd0);
      checkOutput("idle rvalid rd_op_o", 32'(rd_op_o), 32'd0);

      // Reset while waiting for load data.
      applyStimulus(ALU_ADD, 32'h0, 32'h0, 5'd4, 1'b1, 32'h777);
      tick();
      checkOutput("pre-rst rd_data_o", rd_data_o, 32'h777);
      applyStimulus(ALU_LW, 32'h200, 32'h0, 5'd3, 1'b1, 32'h0);
      tick();
      mem_gnt = 1'b1;
      #1;
      tick();
      mem_gnt = 1'b0;
      checkOutput("wait stall", 32'(stallreq), 32'd1);
      RST = 1'b0;
      #1;
      checkOutput("rst wait req", 32'(mem_req), 32'd0);
      checkOutput("rst wait stall", 32'(stallreq), 32'd0);
      applyStimulus(ALU_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
      tick();
      checkOutput("rst rd_o", 32'(rd_o), 32'd0);
      checkOutput("rst rd_op_o", 32'(rd_op_o), 32'd0);
      checkOutput("rst rd_data_o", rd_data_o, 32'd0);
      RST = 1'b1;
      tick();
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hFFFFFFFF;
      tick();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      checkOutput("late rvalid rd_op_o", 32'(rd_op_o), 32'd0);
      checkOutput("late rvalid rd_data_o", rd_data_o, 32'd0);
      checkOutput("late rvalid stall", 32'(stallreq), 32'd0);

      // Reset while requesting drops mem_req immediately.
      applyStimulus(ALU_LW, 32'h300, 32'h0, 5'd2, 1'b1, 32'h0);
      tick();
      checkOutput("req before rst", 32'(mem_req), 32'd1);
      RST = 1'b0;
      #1;
      checkOutput("req during rst", 32'(mem_req), 32'd0);
      applyStimulus(ALU_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
      tick();
      RST = 1'b1;
      tick();
      checkOutput("req after rst", 32'(mem_req), 32'd0);

`ifdef MISALIGN_TRAP_EN
      // Misaligned word traps without touching the bus.
      applyStimulus(ALU_LW, 32'h102, 32'h0, 5'd6, 1'b1, 32'h0);
      #1;
      checkOutput("mis stall", 32'(stallreq), 32'd0);
      tick();
      checkOutput("mis req", 32'(mem_req), 32'd0);
      checkOutput("mis misalign_o", 32'(misalign_o), 32'd1);
      checkOutput("mis badaddr_o", badaddr_o, 32'h102);
      checkOutput("mis rd_op_o", 32'(rd_op_o), 32'd0);
      applyStimulus(ALU_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
      tick();
      checkOutput("mis pulse end", 32'(misalign_o), 32'd0);
      checkOutput("mis req after", 32'(mem_req), 32'd0);
`else
      // Misaligned word is forced onto the aligned word.
      applyStimulus(ALU_LW, 32'h102, 32'h0, 5'd6, 1'b1, 32'h0);
      tick();
      checkOutput("force req", 32'(mem_req), 32'd1);
      checkOutput("force addr", mem_addr, 32'h100);
      checkOutput("force be", 32'(mem_be), 32'hF);
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h11223344;
      #1;
      applyStimulus(ALU_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
      tick();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      checkOutput("force rd_data_o", rd_data_o, 32'h11223344);
      checkOutput("force rd_o", 32'(rd_o), 32'd6);
`endif

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
